// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline types and constants for the RV32IM front end.
// Holds the fetch FSM encoding, the IF/ID payload layout and the reset/bubble words.
package rv32_pipeline_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: one-cycle load; flush beats stall, stall holds every field.
// No backpressure of its own; an idle non-stalled cycle loads a bubble.
module if_id_register
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
    input  logic        core_clk,
    input  logic        arst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_vld,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_pc4,
    input  logic [31:0] load_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_vld
);

    localparam if_id_t IFID_RESET = '{pc: 32'h0, pc4: 32'h4, instr: NOP_INSTR, valid: 1'b0};

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            if (load_vld) begin
                ifid_d = '{pc: load_pc, pc4: load_pc4, instr: load_instr, valid: 1'b1};
            end else begin
                // Bubble: PC fields keep their last values, only the payload is killed.
                ifid_d.instr = NOP_INSTR;
                ifid_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            ifid_q <= IFID_RESET;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_pc    = ifid_q.pc;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_instr = ifid_q.instr;
    assign ifid_vld   = ifid_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the IMEM READ/BUSYWAIT handshake, feeds IF/ID; 1+N cycles per instruction.
// Decode STALL parks a completed word in a one-entry hold buffer; EX redirects kill in-flight fetches.
module instruction_fetch_unit
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = rv32_pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READINST,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         read_q, read_d;
    logic         kill_q, kill_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    logic         ifid_load;
    logic [31:0]  ifid_load_instr;
    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = word_align(BRANCH_TARGET);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        kill_d          = kill_q;
        redirect_pc_d   = redirect_pc_q;
        hold_instr_d    = hold_instr_q;
        ifid_load       = 1'b0;
        ifid_load_instr = IMEM_READINST;
        case (state_q)
            IDLE: begin
                if (BRANCH_TAKEN) begin
                    pc_d = target_aligned;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (BRANCH_TAKEN) begin
                        pc_d = target_aligned;
                    end else if (kill_q) begin
                        pc_d = redirect_pc_q;
                    end else if (STALL) begin
                        hold_instr_d = IMEM_READINST;
                        state_d      = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end
                end else if (BRANCH_TAKEN) begin
                    // Memory is mid-access: keep the address stable and squash the word on arrival.
                    kill_d        = 1'b1;
                    redirect_pc_d = target_aligned;
                end
            end
            HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_d    = target_aligned;
                    state_d = IDLE;
                end else if (!STALL) begin
                    ifid_load       = 1'b1;
                    ifid_load_instr = hold_instr_q;
                    pc_d            = pc_plus4;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        read_d = (state_d == FETCH);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            read_q        <= 1'b0;
            kill_q        <= 1'b0;
            redirect_pc_q <= RESET_PC;
            hold_instr_q  <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            read_q        <= read_d;
            kill_q        <= kill_d;
            redirect_pc_q <= redirect_pc_d;
            hold_instr_q  <= hold_instr_d;
        end
    end

    assign IMEM_READ    = read_q;
    assign IMEM_ADDRESS = pc_q;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_register (
        .core_clk   (CLK),
        .arst_n     (RESET_N),
        .flush      (BRANCH_TAKEN),
        .stall      (STALL),
        .load_vld   (ifid_load),
        .load_pc    (pc_q),
        .load_pc4   (pc_plus4),
        .load_instr (ifid_load_instr),
        .ifid_pc    (IFID_PC),
        .ifid_pc4   (IFID_PC4),
        .ifid_instr (IFID_INSTR),
        .ifid_vld   (IFID_VALID)
    );

endmodule
